// File: rtl/raw2rgb_pkg.sv
// Shared types and default widths for the raw Bayer to RGB demosaic pipeline.
package raw2rgb_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_LINE_W = 1280;
    localparam int DEF_CNT_W  = 16;

    // One raw sample or colour channel at the default width.
    typedef logic [DEF_DATA_W-1:0] pixel_t;

    // Colour of the current sample D inside the 2x2 Bayer tile G1 R / B G2.
    typedef enum logic [1:0] {
        PH_G1 = 2'b00,
        PH_R  = 2'b01,
        PH_B  = 2'b10,
        PH_G2 = 2'b11
    } bayer_phase_e;

    // Tile position of a sample, after the {y-flip, x-flip} pattern offset.
    function automatic bayer_phase_e bayer_phase(input logic y_lsb, input logic x_lsb,
                                                 input logic [1:0] flip);
        return bayer_phase_e'({y_lsb ^ flip[1], x_lsb ^ flip[0]});
    endfunction

endpackage

// File: rtl/raw2rgb_pipe_if.sv
// Sample write port: one raw sample, its column position and a valid strobe.
// valid=1 means data and pos are meaningful this cycle and are consumed on
// the rising clock edge; there is no back-pressure (the consumer is always ready).
interface raw2rgb_pipe_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 11
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic [ADDR_W-1:0] pos;

    modport master (output data, valid, pos);
    modport slave  (input  data, valid, pos);
endinterface

// File: rtl/raw2rgb_linebuf.sv
// One-line sample store: single-port, read-before-write, registered read.
// The old word at the written address comes out one cycle later as the
// sample directly above the one being written.
module raw2rgb_linebuf #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 1280,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    raw2rgb_pipe_if.slave     wr_if,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [LINE_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage array: written with each accepted sample, never cleared.
    always_ff @(posedge clk_i) begin
        if (wr_if.valid) begin
            mem_q[wr_if.pos] <= wr_if.data;
        end
    end

    // Read register: captures the old word at the write address, holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (wr_if.valid) begin
            rdata_q <= mem_q[wr_if.pos];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/raw2rgb_pipe.sv
// Bilinear 2x2 Bayer demosaic with a fixed two-cycle latency.
// Stage 1 captures the sample, the pixel above (line buffer) and the window
// history; stage 2 selects channels by Bayer phase and registers the result.
// Optional feature macro: RAW2RGB_GRAY_EN enables the iSW grayscale output.
module raw2rgb_pipe
    import raw2rgb_pkg::*;
#(
    parameter int         DATA_W      = DEF_DATA_W,
    parameter int         LINE_W      = DEF_LINE_W,
    parameter int         CNT_W       = DEF_CNT_W,
    parameter logic [1:0] BAYER_PHASE = 2'b00
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [CNT_W-1:0]  iX_Cont,
    input  logic [CNT_W-1:0]  iY_Cont,
    input  logic              iSW,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL,
    output logic              oOVF
);

    localparam int               ADDR_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [CNT_W-1:0] X_LIMIT = CNT_W'(LINE_W);

    logic in_range;
    logic accept;
    logic ovf_hit;
    logic [DATA_W-1:0] above;

    assign in_range = (iX_Cont < X_LIMIT);
    assign accept   = iDVAL & in_range;
    assign ovf_hit  = iDVAL & ~in_range;

    raw2rgb_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_if ();

    assign wr_if.valid = accept;
    assign wr_if.data  = iDATA;
    assign wr_if.pos   = iX_Cont[ADDR_W-1:0];

    raw2rgb_linebuf #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W),
        .ADDR_W (ADDR_W)
    ) u_linebuf (
        .clk_i   (iCLK),
        .rst_ni  (iRST),
        .wr_if   (wr_if),
        .rdata_o (above)
    );

    // Stage 1 state. B is the line-buffer read register itself; A is the
    // previous B and C the previous D, so gaps simply freeze the window.
    logic              v1_q;
    logic [DATA_W-1:0] a1_q;
    logic [DATA_W-1:0] c1_q;
    logic [DATA_W-1:0] d1_q;
    logic              x0_q;
    logic              y0_q;
    bayer_phase_e      ph1_q;
`ifdef RAW2RGB_GRAY_EN
    logic              sw1_q;
`else
    logic              unused_sw;
    assign unused_sw = iSW;
`endif

    // Stage 1: shift the 2x2 window on each accepted sample, hold on gaps.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            v1_q  <= 1'b0;
            a1_q  <= '0;
            c1_q  <= '0;
            d1_q  <= '0;
            x0_q  <= 1'b0;
            y0_q  <= 1'b0;
            ph1_q <= PH_G1;
`ifdef RAW2RGB_GRAY_EN
            sw1_q <= 1'b0;
`endif
        end else begin
            v1_q <= accept;
            if (accept) begin
                a1_q  <= above;
                c1_q  <= d1_q;
                d1_q  <= iDATA;
                x0_q  <= (iX_Cont == '0);
                y0_q  <= (iY_Cont == '0);
                ph1_q <= bayer_phase(iY_Cont[0], iX_Cont[0], BAYER_PHASE);
`ifdef RAW2RGB_GRAY_EN
                sw1_q <= iSW;
`endif
            end
        end
    end

    logic [DATA_W-1:0] a_pix, b_pix, c_pix, d_pix;
    logic [DATA_W:0]   sum_ad, sum_bc;
    logic [DATA_W-1:0] red_d, green_d, blue_d;
`ifdef RAW2RGB_GRAY_EN
    logic [DATA_W+1:0] gray_sum;
`endif

    // Stage 2 combinational: edge replication, then phase-driven channel pick.
    always_comb begin
        // Top row takes the current row for A/B; left column takes column 0 for A/C.
        b_pix = y0_q ? d1_q : above;
        a_pix = x0_q ? b_pix : (y0_q ? c1_q : a1_q);
        c_pix = x0_q ? d1_q : c1_q;
        d_pix = d1_q;

        sum_ad = {1'b0, a_pix} + {1'b0, d_pix};
        sum_bc = {1'b0, b_pix} + {1'b0, c_pix};

        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        case (ph1_q)
            PH_G1: begin red_d = c_pix; blue_d = b_pix; green_d = sum_ad[DATA_W:1]; end
            PH_R:  begin red_d = d_pix; blue_d = a_pix; green_d = sum_bc[DATA_W:1]; end
            PH_B:  begin red_d = a_pix; blue_d = d_pix; green_d = sum_bc[DATA_W:1]; end
            PH_G2: begin red_d = b_pix; blue_d = c_pix; green_d = sum_ad[DATA_W:1]; end
            default: begin red_d = '0; blue_d = '0; green_d = '0; end
        endcase

`ifdef RAW2RGB_GRAY_EN
        gray_sum = {2'b00, red_d} + {1'b0, green_d, 1'b0} + {2'b00, blue_d};
        if (sw1_q) begin
            red_d   = gray_sum[DATA_W+1:2];
            green_d = gray_sum[DATA_W+1:2];
            blue_d  = gray_sum[DATA_W+1:2];
        end
`endif
    end

    logic [DATA_W-1:0] red_q, green_q, blue_q;
    logic              dval_q;
    logic              ovf_q;

    // Stage 2 registers: load on a valid stage-1 slot, otherwise hold colour.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            dval_q  <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            dval_q <= v1_q;
            if (v1_q) begin
                red_q   <= red_d;
                green_q <= green_d;
                blue_q  <= blue_d;
            end
        end
    end

    // Sticky overflow: any valid sample beyond the line buffer sets it until reset.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            ovf_q <= 1'b0;
        end else if (ovf_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign oRed   = red_q;
    assign oGreen = green_q;
    assign oBlue  = blue_q;
    assign oDVAL  = dval_q;
    assign oOVF   = ovf_q;

endmodule

// File: tb/tb_raw2rgb_pipe.sv
// Directed bench for raw2rgb_pipe (DATA_W=12, LINE_W=8, BAYER_PHASE=0).
// An image-array model derives every output from neighbouring pixels and is
// compared each cycle; literal checks pin the model on hand-worked cases.
module tb_raw2rgb_pipe;
    import raw2rgb_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [15:0] iY_Cont;
    logic        iSW;
    pixel_t      oRed, oGreen, oBlue;
    logic        oDVAL, oOVF;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    raw2rgb_pipe_if #(.DATA_W(12), .ADDR_W(16)) drv_if ();

    raw2rgb_pipe #(
        .DATA_W      (12),
        .LINE_W      (8),
        .CNT_W       (16),
        .BAYER_PHASE (2'b00)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iDATA   (drv_if.data),
        .iDVAL   (drv_if.valid),
        .iX_Cont (drv_if.pos),
        .iY_Cont (iY_Cont),
        .iSW     (iSW),
        .oRed    (oRed),
        .oGreen  (oGreen),
        .oBlue   (oBlue),
        .oDVAL   (oDVAL),
        .oOVF    (oOVF)
    );

    // ---------------- clock ----------------
    always #5 iCLK = ~iCLK;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [11:0] img [0:3][0:7];
    logic        m_v1  = 1'b0;
    logic [35:0] m_px1 = '0;
    logic        m_dval = 1'b0;
    logic [35:0] m_rgb = '0;
    logic        m_ovf = 1'b0;

    // Neighbour fetch with edge replication (clamp to row 0 / column 0).
    function automatic logic [11:0] pix_at(int xx, int yy, int cx, int cy, logic [11:0] cd);
        if (xx < 0) xx = 0;
        if (yy < 0) yy = 0;
        if (xx == cx && yy == cy) return cd;
        return img[yy][xx];
    endfunction

    function automatic logic [35:0] expect_rgb(int x, int y, logic [11:0] d, logic sw);
        int a, b, c, dd, r, g, bl;
        a  = int'(pix_at(x - 1, y - 1, x, y, d));
        b  = int'(pix_at(x,     y - 1, x, y, d));
        c  = int'(pix_at(x - 1, y,     x, y, d));
        dd = int'(d);
        case ({y[0], x[0]})
            2'b00:   begin r = c;  bl = b;  g = (a + dd) / 2; end
            2'b01:   begin r = dd; bl = a;  g = (b + c) / 2;  end
            2'b10:   begin r = a;  bl = dd; g = (b + c) / 2;  end
            default: begin r = b;  bl = c;  g = (a + dd) / 2; end
        endcase
`ifdef RAW2RGB_GRAY_EN
        if (sw) begin
            r = (r + 2 * g + bl) / 4;
            g = r;
            bl = r;
        end
`else
        if (sw) begin
            r = r + 0;
        end
`endif
        return {12'(r), 12'(g), 12'(bl)};
    endfunction

    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            m_v1   <= 1'b0;
            m_px1  <= '0;
            m_dval <= 1'b0;
            m_rgb  <= '0;
            m_ovf  <= 1'b0;
        end else begin
            m_dval <= m_v1;
            if (m_v1) m_rgb <= m_px1;
            m_v1 <= 1'b0;
            if (drv_if.valid && drv_if.pos < 16'd8) begin
                m_v1  <= 1'b1;
                m_px1 <= expect_rgb(int'(drv_if.pos), int'(iY_Cont), drv_if.data, iSW);
                img[int'(iY_Cont)][int'(drv_if.pos)] <= drv_if.data;
            end else if (drv_if.valid) begin
                m_ovf <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge iCLK) begin
        if (chk_en) begin
            check("cmp_dval",  {11'd0, oDVAL}, {11'd0, m_dval});
            check("cmp_red",   oRed,   m_rgb[35:24]);
            check("cmp_green", oGreen, m_rgb[23:12]);
            check("cmp_blue",  oBlue,  m_rgb[11:0]);
            check("cmp_ovf",   {11'd0, oOVF}, {11'd0, m_ovf});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [11:0] d, input logic [15:0] x,
                         input logic [15:0] y);
        drv_if.valid = v;
        drv_if.data  = d;
        drv_if.pos   = x;
        iY_Cont      = y;
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [11:0] pattern(int mode, int x, int y);
        case (mode)
            0:       return 12'h0A0;
            1:       return 12'(x * 37 + y * 211 + 5);
            default: return 12'(4095 - x * 3 - y * 7);
        endcase
    endfunction

    // Full frame; with gap set, an idle cycle (junk position) follows column 1.
    task automatic frame(input int w, input int h, input int mode, input logic gap);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                drive(1'b1, pattern(mode, x, y), 16'(x), 16'(y));
                if (gap && x == 1) drive(1'b0, 12'hFFF, 16'd9, 16'(y));
            end
        end
        drive(1'b0, 12'h000, 16'd0, 16'd0);
        drive(1'b0, 12'h000, 16'd0, 16'd0);
    endtask

    // 2x2 demosaic vector; the (1,1) result is on the outputs when it returns.
    task automatic demo(input logic gap);
        drive(1'b1, 12'h010, 16'd0, 16'd0);
        drive(1'b1, 12'h020, 16'd1, 16'd0);
        drive(1'b1, 12'h030, 16'd0, 16'd1);
        if (gap) drive(1'b0, 12'h777, 16'd1, 16'd1);
        drive(1'b1, 12'h040, 16'd1, 16'd1);
        drive(1'b0, 12'h000, 16'd0, 16'd0);
    endtask

    task automatic check_demo(input string tag);
        check({tag, "_dval"}, {11'd0, oDVAL}, 12'h001);
`ifdef RAW2RGB_GRAY_EN
        check({tag, "_red"},   oRed,   12'h028);
        check({tag, "_green"}, oGreen, 12'h028);
        check({tag, "_blue"},  oBlue,  12'h028);
`else
        check({tag, "_red"},   oRed,   12'h020);
        check({tag, "_green"}, oGreen, 12'h028);
        check({tag, "_blue"},  oBlue,  12'h030);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        iRST         = 1'b1;
        drv_if.valid = 1'b0;
        drv_if.data  = '0;
        drv_if.pos   = '0;
        iY_Cont      = '0;
        iSW          = 1'b0;
        #3 iRST = 1'b0;
        #1 chk_en = 1'b1;

        // Reset held while data streams in.
        for (int i = 0; i < 6; i++) drive(1'b1, 12'(12'h100 + i), 16'(i), 16'd0);
        check("lit_rst_dval", {11'd0, oDVAL}, 12'h000);
        check("lit_rst_red",  oRed,  12'h000);
        check("lit_rst_ovf",  {11'd0, oOVF}, 12'h000);
        iRST = 1'b1;
        drive(1'b0, 12'h000, 16'd0, 16'd0);

        // Flat field.
        frame(4, 4, 0, 1'b0);
        check("lit_flat_red",   oRed,   12'h0A0);
        check("lit_flat_green", oGreen, 12'h0A0);
        check("lit_flat_blue",  oBlue,  12'h0A0);

        // Demosaic vector, with and without an intra-line gap, grayscale selected.
        iSW = 1'b1;
        demo(1'b0);
        check_demo("lit_demo");
        drive(1'b0, 12'h000, 16'd0, 16'd0);
        demo(1'b1);
        check_demo("lit_demo_gap");
        drive(1'b0, 12'h000, 16'd0, 16'd0);
        iSW = 1'b0;

        // Varied and near-full-scale frames over the whole line width.
        frame(8, 4, 1, 1'b1);
        frame(8, 3, 2, 1'b0);

        // Overflow: full row then a sample at column 8.
        for (int x = 0; x < 9; x++) drive(1'b1, pattern(1, x, 0), 16'(x), 16'd0);
        drive(1'b0, 12'h000, 16'd0, 16'd0);
        check("lit_ovf_nodval", {11'd0, oDVAL}, 12'h000);
        check("lit_ovf_set",    {11'd0, oOVF},  12'h001);
        frame(2, 2, 0, 1'b0);
        check("lit_ovf_held", {11'd0, oOVF}, 12'h001);

        // Reset in the middle of a line, then restart from row 0.
        drive(1'b1, 12'h123, 16'd0, 16'd0);
        drive(1'b1, 12'h456, 16'd1, 16'd0);
        drive(1'b1, 12'h789, 16'd2, 16'd0);
        iRST = 1'b0;
        #1;
        check("lit_midrst_dval", {11'd0, oDVAL}, 12'h000);
        check("lit_midrst_red",  oRed,  12'h000);
        check("lit_midrst_ovf",  {11'd0, oOVF}, 12'h000);
        drive(1'b1, 12'hABC, 16'd3, 16'd0);
        iRST = 1'b1;
        drive(1'b0, 12'h000, 16'd0, 16'd0);
        frame(8, 4, 1, 1'b1);
        demo(1'b0);
        check_demo("lit_demo_after_rst");
        drive(1'b0, 12'h000, 16'd0, 16'd0);
        drive(1'b0, 12'h000, 16'd0, 16'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
